// File: rtl/mux2_stream_arbiter_if.sv
// Stream bundle for mux2_stream_arbiter: two requester streams in, one stream out,
// plus the current mux select (grant).
//
// Handshake: a beat moves on a rising clk edge only when the sender holds val=1
// and the receiver shows rdy=1 in that cycle. A sender that raised val keeps
// val and msg/last stable until that edge. rdy may depend combinationally on val.
interface mux2_stream_arbiter_if #(
    parameter int NBITS = 8
);
    logic             in0_val;
    logic             in0_rdy;
    logic [NBITS-1:0] in0_msg;
    logic             in0_last;
    logic             in1_val;
    logic             in1_rdy;
    logic [NBITS-1:0] in1_msg;
    logic             in1_last;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_msg;
    logic             out_last;
    logic             grant;

    // Requesters and downstream sink side
    modport master (
        output in0_val, in0_msg, in0_last,
        output in1_val, in1_msg, in1_last,
        output out_rdy,
        input  in0_rdy, in1_rdy,
        input  out_val, out_msg, out_last, grant
    );

    // Arbiter side
    modport slave (
        input  in0_val, in0_msg, in0_last,
        input  in1_val, in1_msg, in1_last,
        input  out_rdy,
        output in0_rdy, in1_rdy,
        output out_val, out_msg, out_last, grant
    );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: round-robin arbiter sharing one 2:1 mux between two
// val/rdy requester streams. Zero-latency (val, msg and rdy are combinational);
// the grant is frozen while the output is stalled so out_msg stays stable.
//
// Optional packet lock: define MUX2_STREAM_ARBITER_PKT_LOCK_EN to keep the grant
// on one requester from the first beat of a packet until its beat with last=1.
// Without the macro, arbitration is per beat and in*_last only pass through.
//
// o_dbg_state exposes the FSM state: 0 = ARB, 1 = HOLD, 2 = LOCK.
module mux2_stream_arbiter #(
    parameter int NBITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    mux2_stream_arbiter_if.slave    bus,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HOLD = 2'd1
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
        ,
        ST_LOCK = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_prio;
    logic             r_sel_q;

    logic             w_grant;
    logic             w_out_val;
    logic             w_out_last;
    logic [NBITS-1:0] w_out_msg;
    logic             w_xfer;
    logic             w_stall;
    logic             w_prio_upd;

    // Grant: free choice only in ARB; HOLD/LOCK replay the registered select
    always_comb begin
        w_grant = r_prio;
        case (r_state)
            ST_ARB: begin
                if (bus.in0_val && bus.in1_val) begin
                    w_grant = r_prio;
                end else if (bus.in1_val) begin
                    w_grant = 1'b1;
                end else if (bus.in0_val) begin
                    w_grant = 1'b0;
                end else begin
                    w_grant = r_prio;
                end
            end
            default: w_grant = r_sel_q;
        endcase
        if (reset) begin
            w_grant = 1'b0;
        end
    end

    // Datapath mux and handshake gating; everything is quiet while reset is high
    always_comb begin
        w_out_val  = ~reset & (w_grant ? bus.in1_val : bus.in0_val);
        w_out_msg  = w_grant ? bus.in1_msg : bus.in0_msg;
        w_out_last = w_grant ? bus.in1_last : bus.in0_last;
        w_xfer     = w_out_val & bus.out_rdy;
        w_stall    = w_out_val & ~bus.out_rdy;
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
        w_prio_upd = w_xfer & w_out_last;
`else
        w_prio_upd = w_xfer;
`endif
    end

    assign bus.out_val  = w_out_val;
    assign bus.out_msg  = w_out_msg;
    assign bus.out_last = w_out_last;
    assign bus.grant    = w_grant;
    assign bus.in0_rdy  = ~reset & bus.out_rdy & ~w_grant;
    assign bus.in1_rdy  = ~reset & bus.out_rdy &  w_grant;
    assign o_dbg_state  = r_state;

    // Next-state logic: stall freezes the grant, a transfer releases it
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB: begin
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
                if (w_xfer && !w_out_last) begin
                    w_next_state = ST_LOCK;
                end else if (w_stall) begin
                    w_next_state = ST_HOLD;
                end
`else
                if (w_stall) begin
                    w_next_state = ST_HOLD;
                end
`endif
            end
            ST_HOLD: begin
                // A requester dropping val here is a protocol violation; stay put
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
                if (w_xfer) begin
                    w_next_state = w_out_last ? ST_ARB : ST_LOCK;
                end
`else
                if (w_xfer) begin
                    w_next_state = ST_ARB;
                end
`endif
            end
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
            ST_LOCK: begin
                // Stalls inside a packet keep the lock
                if (w_xfer && w_out_last) begin
                    w_next_state = ST_ARB;
                end
            end
`endif
            default: w_next_state = ST_ARB;
        endcase
    end

    // State, registered select and round-robin priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARB;
            r_prio  <= 1'b0;
            r_sel_q <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_out_val) begin
                r_sel_q <= w_grant;
            end
            if (w_prio_upd) begin
                r_prio <= ~w_grant;
            end
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Directed bench for mux2_stream_arbiter: reset, solo requester, alternation,
// stall hold, packet lock (both macro settings) and reset mid-packet.
module tb_mux2_stream_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_err;

    mux2_stream_arbiter_if #(.NBITS(8)) bus ();

    mux2_stream_arbiter #(.NBITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_msg[4];
    logic       exp_g[4];
    int         k;

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset        = 1'b1;
        bus.in0_val  = 1'b1;
        bus.in0_msg  = 8'h00;
        bus.in0_last = 1'b1;
        bus.in1_val  = 1'b1;
        bus.in1_msg  = 8'h00;
        bus.in1_last = 1'b1;
        bus.out_rdy  = 1'b1;

        // Reset held with requests present: everything quiet
        cyc();
        #2;
        chk("rst_out_val", bus.out_val, 1'b0);
        chk("rst_in0_rdy", bus.in0_rdy, 1'b0);
        chk("rst_in1_rdy", bus.in1_rdy, 1'b0);
        chk("rst_grant",   bus.grant,   1'b0);
        chk("rst_state",   dbg_state,   2'd0);
        cyc();
        reset       = 1'b0;
        bus.in0_val = 1'b0;
        bus.in1_val = 1'b0;

        // Solo requester 1
        cyc();
        bus.in1_val = 1'b1;
        bus.in1_msg = 8'hA5;
        #2;
        chk("solo_grant",   bus.grant,   1'b1);
        chk("solo_msg",     bus.out_msg, 8'hA5);
        chk("solo_out_val", bus.out_val, 1'b1);
        chk("solo_in1_rdy", bus.in1_rdy, 1'b1);
        chk("solo_in0_rdy", bus.in0_rdy, 1'b0);
        cyc();
        bus.in1_val = 1'b0;

        // Fair alternation: prio is back at 0 after the solo in1 beat
        cyc();
        bus.in0_val = 1'b1;
        bus.in0_msg = 8'h11;
        bus.in1_val = 1'b1;
        bus.in1_msg = 8'h22;
        #2;
        chk("alt0_msg", bus.out_msg, 8'h11);
        chk("alt0_grant", bus.grant, 1'b0);
        cyc();
        #2;
        chk("alt1_msg", bus.out_msg, 8'h22);
        chk("alt1_in1_rdy", bus.in1_rdy, 1'b1);
        chk("alt1_in0_rdy", bus.in0_rdy, 1'b0);
        cyc();
        #2;
        chk("alt2_msg", bus.out_msg, 8'h11);
        cyc();
        #2;
        chk("alt3_msg", bus.out_msg, 8'h22);
        cyc();

        // Stall hold: 3 stalled cycles on in0's beat, then release
        bus.out_rdy = 1'b0;
        #2;
        chk("stall0_msg",     bus.out_msg, 8'h11);
        chk("stall0_out_val", bus.out_val, 1'b1);
        chk("stall0_in0_rdy", bus.in0_rdy, 1'b0);
        cyc();
        #2;
        chk("stall1_state", dbg_state,   2'd1);
        chk("stall1_msg",   bus.out_msg, 8'h11);
        cyc();
        #2;
        chk("stall2_grant", bus.grant,   1'b0);
        chk("stall2_msg",   bus.out_msg, 8'h11);
        cyc();
        bus.out_rdy = 1'b1;
        #2;
        chk("stall_rel_msg", bus.out_msg, 8'h11);
        chk("stall_rel_rdy", bus.in0_rdy, 1'b1);
        cyc();
        #2;
        chk("stall_next_msg", bus.out_msg, 8'h22);
        chk("stall_next_grant", bus.grant, 1'b1);
        cyc();

        // Stalled in1 beat keeps the grant even when in0 (the tie winner) appears
        bus.in0_val = 1'b0;
        bus.in1_msg = 8'h66;
        bus.out_rdy = 1'b0;
        #2;
        chk("hold1_grant", bus.grant, 1'b1);
        cyc();
        bus.in0_val = 1'b1;
        #2;
        chk("hold1_grant_frozen", bus.grant,   1'b1);
        chk("hold1_msg_frozen",   bus.out_msg, 8'h66);
        chk("hold1_in0_rdy",      bus.in0_rdy, 1'b0);
        cyc();
        bus.out_rdy = 1'b1;
        #2;
        chk("hold1_rel_in1_rdy", bus.in1_rdy, 1'b1);
        cyc();

        // Packet of 3 beats from in0 while in1 keeps requesting single beats
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
        exp_msg = '{8'h31, 8'h32, 8'h33, 8'h44};
        exp_g   = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_msg = '{8'h31, 8'h44, 8'h32, 8'h44};
        exp_g   = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        bus.in1_msg  = 8'h44;
        bus.in1_last = 1'b1;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            bus.in0_msg  = 8'(8'h31 + k);
            bus.in0_last = (k == 2);
            #2;
            chk($sformatf("pkt%0d_grant", c), bus.grant,   exp_g[c]);
            chk($sformatf("pkt%0d_msg", c),   bus.out_msg, exp_msg[c]);
            if (c == 1) begin
`ifdef MUX2_STREAM_ARBITER_PKT_LOCK_EN
                chk("pkt_lock_state", dbg_state, 2'd2);
`else
                chk("pkt_lock_state", dbg_state, 2'd0);
`endif
            end
            if (exp_g[c] == 1'b0) k++;
            cyc();
        end

        // Reset during beat 2 of an in1 packet
        bus.in0_val  = 1'b0;
        bus.in0_last = 1'b1;
        bus.in1_msg  = 8'h55;
        bus.in1_last = 1'b0;
        #2;
        chk("rmp_beat1_grant", bus.grant, 1'b1);
        cyc();
        bus.in1_msg = 8'h56;
        #1;
        reset = 1'b1;
        #1;
        chk("rmp_out_val", bus.out_val, 1'b0);
        chk("rmp_in0_rdy", bus.in0_rdy, 1'b0);
        chk("rmp_in1_rdy", bus.in1_rdy, 1'b0);
        chk("rmp_grant",   bus.grant,   1'b0);
        chk("rmp_state",   dbg_state,   2'd0);
        cyc();
        reset        = 1'b0;
        bus.in0_val  = 1'b1;
        bus.in0_msg  = 8'h77;
        bus.in1_last = 1'b1;
        #2;
        chk("rmp_after_grant", bus.grant,   1'b0);
        chk("rmp_after_msg",   bus.out_msg, 8'h77);
        cyc();
        #2;
        chk("rmp_after2_grant", bus.grant, 1'b1);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
